pong_ball_engine: RTL

Parametrised ball engine for the pong datapath. Runs one update per `frame_clk`, i.e. once per video frame. Handles wall bounces and angle-dependent paddle deflection, goal detection and per-player score counters, a timed serve delay and a game-over state. Its outputs drive the sprite drawer (`BallX/BallY/BallS`) and the score display (`Score1/Score2`).

---
 rtl/pong_ball_engine_if.sv | 30 +++
 rtl/pong_ball_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine_if.sv
// Bundle of per-frame controls and ball/score outputs between the pong ball engine and the game logic.
// The master drives Start and both paddles; the slave (engine) drives the ball, scores and state.
interface pong_ball_engine_if #(
  parameter int SCORE_W = 4
);
  logic               Start;
  logic [9:0]         PaddleX;
  logic [9:0]         PaddleY;
  logic [9:0]         PaddleS;
  logic [9:0]         Paddle2X;
  logic [9:0]         Paddle2Y;
  logic [9:0]         Paddle2S;
  logic [9:0]         BallX;
  logic [9:0]         BallY;
  logic [9:0]         BallS;
  logic [SCORE_W-1:0] Score1;
  logic [SCORE_W-1:0] Score2;
  logic               GameOver;
  logic [1:0]         State;

  modport master (
    output Start, PaddleX, PaddleY, PaddleS, Paddle2X, Paddle2Y, Paddle2S,
    input  BallX, BallY, BallS, Score1, Score2, GameOver, State
  );

  modport slave (
    input  Start, PaddleX, PaddleY, PaddleS, Paddle2X, Paddle2Y, Paddle2S,
    output BallX, BallY, BallS, Score1, Score2, GameOver, State
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Per-frame pong ball engine: serve delay, wall/paddle bounces, goals, scores and game over.
// Optional feature macro PONG_BALL_SPEEDUP_EN: each paddle hit speeds the ball up in X.
module pong_ball_engine #(
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int X_CENTER     = 320,
  parameter int Y_CENTER     = 240,
  parameter int BALL_SIZE    = 4,
  parameter int STEP_START   = 2,
  parameter int STEP_MAX     = 8,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4
) (
  input  logic              frame_clk,
  input  logic              Reset,
  pong_ball_engine_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int          CNT_W  = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] L_BS   = 11'(BALL_SIZE);
  localparam logic [10:0] L_XLIM = 11'(X_MAX - BALL_SIZE);
  localparam logic [10:0] L_YLIM = 11'(Y_MAX - BALL_SIZE);
  localparam logic [3:0]  L_STEP0 = 4'(STEP_START);
  localparam logic [3:0]  L_SMAX  = 4'(STEP_MAX);
  localparam logic [SCORE_W-1:0] L_WIN = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  logic [9:0]         r_x, r_y;
  logic [SCORE_W-1:0] r_s1, r_s2;
  logic               r_go;
  logic               r_xdir;   // 1 = right
  logic               r_ydir;   // 1 = down
  logic [3:0]         r_xstep, r_ystep;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_goal_l, w_goal_r, w_hit;
  logic [9:0]         w_px, w_py, w_ps, w_dx, w_dy, w_dy_q;
  logic               w_xdir, w_ydir;
  logic [3:0]         w_xstep, w_ystep;
  logic [10:0]        w_xsum, w_ysum;
  logic [9:0]         w_x_next, w_y_next;
  logic [SCORE_W-1:0] w_s1_inc, w_s2_inc;

  assign w_goal_l = {1'b0, r_x} <= L_BS + {7'd0, r_xstep};
  assign w_goal_r = {1'b0, r_x} + {7'd0, r_xstep} >= L_XLIM;

  // Only the paddle the ball is travelling toward can be hit.
  assign w_px = r_xdir ? bus.Paddle2X : bus.PaddleX;
  assign w_py = r_xdir ? bus.Paddle2Y : bus.PaddleY;
  assign w_ps = r_xdir ? bus.Paddle2S : bus.PaddleS;
  assign w_dx = (r_x >= w_px) ? r_x - w_px : w_px - r_x;
  assign w_dy = (r_y >= w_py) ? r_y - w_py : w_py - r_y;
  assign w_dy_q = w_dy >> 2;
  assign w_hit = ({1'b0, w_dx} <= L_BS) && ({1'b0, w_dy} <= {1'b0, w_ps} + L_BS);

  assign w_s1_inc = (r_s1 >= L_WIN) ? L_WIN : r_s1 + 1'b1;
  assign w_s2_inc = (r_s2 >= L_WIN) ? L_WIN : r_s2 + 1'b1;

  always_comb begin
    w_xdir  = r_xdir;
    w_ydir  = r_ydir;
    w_xstep = r_xstep;
    w_ystep = r_ystep;
    if (w_hit) begin
      w_xdir = ~r_xdir;
      w_ydir = (r_y >= w_py);
      if (w_dy_q > 10'(STEP_MAX))
        w_ystep = L_SMAX;
      else if (w_dy_q == 10'd0)
        w_ystep = 4'd1;
      else
        w_ystep = w_dy_q[3:0];
`ifdef PONG_BALL_SPEEDUP_EN
      w_xstep = (r_xstep >= L_SMAX) ? L_SMAX : r_xstep + 4'd1;
`else
      w_xstep = r_xstep;
`endif
    end
    // Walls take precedence over the paddle's deflection direction.
    if ({1'b0, r_y} <= L_BS + {7'd0, w_ystep})
      w_ydir = 1'b1;
    else if ({1'b0, r_y} + {7'd0, w_ystep} >= L_YLIM)
      w_ydir = 1'b0;

    w_xsum = {1'b0, r_x} + {7'd0, w_xstep};
    w_ysum = {1'b0, r_y} + {7'd0, w_ystep};
    if (w_xdir)
      w_x_next = (w_xsum > L_XLIM) ? L_XLIM[9:0] : w_xsum[9:0];
    else
      w_x_next = ({1'b0, r_x} < L_BS + {7'd0, w_xstep}) ? L_BS[9:0] : r_x - {6'd0, w_xstep};
    if (w_ydir)
      w_y_next = (w_ysum > L_YLIM) ? L_YLIM[9:0] : w_ysum[9:0];
    else
      w_y_next = ({1'b0, r_y} < L_BS + {7'd0, w_ystep}) ? L_BS[9:0] : r_y - {6'd0, w_ystep};
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_x     <= 10'(X_CENTER);
      r_y     <= 10'(Y_CENTER);
      r_s1    <= '0;
      r_s2    <= '0;
      r_go    <= 1'b0;
      r_xdir  <= 1'b0;
      r_ydir  <= 1'b1;
      r_xstep <= L_STEP0;
      r_ystep <= L_STEP0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_OVER: begin
          r_x <= 10'(X_CENTER);
          r_y <= 10'(Y_CENTER);
          if (bus.Start) begin
            r_state <= S_SERVE;
            r_s1    <= '0;
            r_s2    <= '0;
            r_go    <= 1'b0;
            r_cnt   <= CNT_W'(SERVE_FRAMES - 1);
          end
        end
        S_SERVE: begin
          r_x <= 10'(X_CENTER);
          r_y <= 10'(Y_CENTER);
          if (r_cnt == '0) begin
            r_state <= S_PLAY;
            r_xstep <= L_STEP0;
            r_ystep <= L_STEP0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PLAY: begin
          if (w_goal_l || w_goal_r) begin
            r_x     <= 10'(X_CENTER);
            r_y     <= 10'(Y_CENTER);
            r_xdir  <= w_goal_r;
            r_ydir  <= ~r_ydir;
            r_xstep <= L_STEP0;
            r_ystep <= L_STEP0;
            r_cnt   <= CNT_W'(SERVE_FRAMES - 1);
            if (w_goal_l) r_s2 <= w_s2_inc;
            else          r_s1 <= w_s1_inc;
            if ((w_goal_l ? w_s2_inc : w_s1_inc) == L_WIN) begin
              r_state <= S_OVER;
              r_go    <= 1'b1;
            end else begin
              r_state <= S_SERVE;
            end
          end else begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_xdir  <= w_xdir;
            r_ydir  <= w_ydir;
            r_xstep <= w_xstep;
            r_ystep <= w_ystep;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.BallX    = r_x;
  assign bus.BallY    = r_y;
  assign bus.BallS    = 10'(BALL_SIZE);
  assign bus.Score1   = r_s1;
  assign bus.Score2   = r_s2;
  assign bus.GameOver = r_go;
  assign bus.State    = r_state;
endmodule
